pipe_skid_buffer: RTL and testbench

PIPE_SKID_BUFFER -- requirements
Module: pipe_skid_buffer

---
 rtl/pipe_skid_buffer.sv | 118 +++++++++++
 tb/tb_pipe_skid_buffer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer with ready/valid handshake on both sides.
// All state updates on the falling edge of Clk; Rst clears everything asynchronously.
//
// state | meaning
// EMPTY | no beat held; head may still hold stale data when ZERO_ON_EMPTY=0
// ONE   | head holds the beat presented on DataOut/CtrlOut
// FULL  | head presented, skid holds the next beat; upstream is stalled
module pipe_skid_buffer #(
  parameter int DATA_W        = 16,
  parameter int CTRL_W        = 32,
  parameter bit ZERO_ON_EMPTY = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Flush,
  input  logic              InValid,
  input  logic [DATA_W-1:0] DataIn,
  input  logic [CTRL_W-1:0] CtrlIn,
  output logic              InReady,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] DataOut,
  output logic [CTRL_W-1:0] CtrlOut,
  output logic [1:0]        Occupancy
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] head_data, head_data_nxt;
  logic [CTRL_W-1:0] head_ctrl, head_ctrl_nxt;
  logic [DATA_W-1:0] skid_data, skid_data_nxt;
  logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_nxt;
  logic              accept;
  logic              pop;

  // Ready is decoded from the state register only, never from OutReady.
  assign InReady   = (state != FULL) && !Rst;
  assign OutValid  = (state == ONE) || (state == FULL);
  assign Occupancy = state;
  assign accept    = InValid && InReady;
  assign pop       = OutValid && OutReady;

  assign DataOut = (ZERO_ON_EMPTY && !OutValid) ? '0 : head_data;
  assign CtrlOut = (ZERO_ON_EMPTY && !OutValid) ? '0 : head_ctrl;

  always_ff @(negedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= EMPTY;
      head_data <= '0;
      head_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state     <= state_nxt;
      head_data <= head_data_nxt;
      head_ctrl <= head_ctrl_nxt;
      skid_data <= skid_data_nxt;
      skid_ctrl <= skid_ctrl_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    head_data_nxt = head_data;
    head_ctrl_nxt = head_ctrl;
    skid_data_nxt = skid_data;
    skid_ctrl_nxt = skid_ctrl;
    if (Flush) begin
      state_nxt     = EMPTY;
      head_data_nxt = '0;
      head_ctrl_nxt = '0;
      skid_data_nxt = '0;
      skid_ctrl_nxt = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            head_data_nxt = DataIn;
            head_ctrl_nxt = CtrlIn;
            state_nxt     = ONE;
          end
        end
        ONE: begin
          case ({accept, pop})
            2'b10: begin
              skid_data_nxt = DataIn;
              skid_ctrl_nxt = CtrlIn;
              state_nxt     = FULL;
            end
            2'b01: state_nxt = EMPTY;
            2'b11: begin
              head_data_nxt = DataIn;
              head_ctrl_nxt = CtrlIn;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (pop) begin
            head_data_nxt = skid_data;
            head_ctrl_nxt = skid_ctrl;
            skid_data_nxt = '0;
            skid_ctrl_nxt = '0;
            state_nxt     = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Directed bench for pipe_skid_buffer: streaming, stall, drain, flush, async reset.
// A second instance with ZERO_ON_EMPTY=0 shares the stimulus to check hold-last behaviour.
module tb_pipe_skid_buffer;
  localparam int DATA_W = 16;
  localparam int CTRL_W = 32;

  logic              Clk = 1'b1;
  logic              Rst = 1'b1;
  logic              Flush = 1'b0;
  logic              InValid = 1'b0;
  logic [DATA_W-1:0] DataIn = '0;
  logic [CTRL_W-1:0] CtrlIn = '0;
  logic              OutReady = 1'b0;
  logic              InReady, OutValid;
  logic [DATA_W-1:0] DataOut;
  logic [CTRL_W-1:0] CtrlOut;
  logic [1:0]        Occupancy;
  logic              h_in_ready, h_out_valid;
  logic [DATA_W-1:0] h_data_out;
  logic [CTRL_W-1:0] h_ctrl_out;
  logic [1:0]        h_occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  pipe_skid_buffer #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .ZERO_ON_EMPTY(1'b1)) dut (
    .Clk(Clk), .Rst(Rst), .Flush(Flush), .InValid(InValid), .DataIn(DataIn),
    .CtrlIn(CtrlIn), .InReady(InReady), .OutValid(OutValid), .OutReady(OutReady),
    .DataOut(DataOut), .CtrlOut(CtrlOut), .Occupancy(Occupancy)
  );

  pipe_skid_buffer #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .ZERO_ON_EMPTY(1'b0)) u_hold (
    .Clk(Clk), .Rst(Rst), .Flush(Flush), .InValid(InValid), .DataIn(DataIn),
    .CtrlIn(CtrlIn), .InReady(h_in_ready), .OutValid(h_out_valid), .OutReady(OutReady),
    .DataOut(h_data_out), .CtrlOut(h_ctrl_out), .Occupancy(h_occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past one falling edge; outputs are then stable for checking.
  task automatic cycle();
    @(negedge Clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    InValid = 1'b1;
    DataIn  = d;
    CtrlIn  = {16'hC0DE, d};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held across clock edges
    #2;
    chk("rst_occ", Occupancy, 0);
    chk("rst_inready", InReady, 0);
    chk("rst_outvalid", OutValid, 0);
    chk("rst_dataout", DataOut, 0);
    chk("rst_ctrlout", CtrlOut, 0);
    push(16'h9999);
    cycle();
    cycle();
    chk("rst_hold_occ", Occupancy, 0);
    chk("rst_hold_inready", InReady, 0);
    InValid = 1'b0;
    Rst = 1'b0;
    #1;
    chk("rel_inready", InReady, 1);

    // streaming with OutReady high
    OutReady = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      push(16'(i));
      cycle();
      chk("stream_valid", OutValid, 1);
      chk("stream_data", DataOut, 64'(i));
      chk("stream_ctrl", CtrlOut, {32'h0, 16'hC0DE, 16'(i)});
      chk("stream_occ", Occupancy, 1);
    end
    InValid = 1'b0;
    cycle();
    chk("stream_end_valid", OutValid, 0);
    chk("stream_end_data", DataOut, 0);
    chk("stream_end_occ", Occupancy, 0);
    chk("hold_stream_data", h_data_out, 16'h0005);
    chk("hold_stream_valid", h_out_valid, 0);

    // stall fill
    OutReady = 1'b0;
    push(16'hAAAA);
    cycle();
    chk("fill1_occ", Occupancy, 1);
    chk("fill1_inready", InReady, 1);
    chk("fill1_data", DataOut, 16'hAAAA);
    push(16'hBBBB);
    cycle();
    chk("fill2_occ", Occupancy, 2);
    chk("fill2_inready", InReady, 0);
    chk("fill2_data", DataOut, 16'hAAAA);
    push(16'hCCCC);
    cycle();
    chk("fill3_occ", Occupancy, 2);
    chk("fill3_data", DataOut, 16'hAAAA);

    // drain
    InValid = 1'b0;
    OutReady = 1'b1;
    #1;
    chk("drain0_data", DataOut, 16'hAAAA);
    chk("drain0_inready", InReady, 0);
    cycle();
    chk("drain1_data", DataOut, 16'hBBBB);
    chk("drain1_ctrl", CtrlOut, 32'hC0DEBBBB);
    chk("drain1_inready", InReady, 1);
    chk("drain1_occ", Occupancy, 1);
    cycle();
    chk("drain2_valid", OutValid, 0);
    chk("drain2_data", DataOut, 0);
    chk("drain2_occ", Occupancy, 0);
    chk("hold_drain_data", h_data_out, 16'hBBBB);
    cycle();
    chk("drain3_data", DataOut, 0);

    // simultaneous accept and pop in ONE
    OutReady = 1'b0;
    push(16'h1111);
    cycle();
    chk("ap_head", DataOut, 16'h1111);
    OutReady = 1'b1;
    push(16'h2222);
    cycle();
    chk("ap_data", DataOut, 16'h2222);
    chk("ap_occ", Occupancy, 1);
    InValid = 1'b0;
    cycle();
    chk("ap_empty_occ", Occupancy, 0);

    // flush in FULL with an input beat presented
    OutReady = 1'b0;
    push(16'h4444);
    cycle();
    push(16'h5555);
    cycle();
    chk("fl_full_occ", Occupancy, 2);
    Flush = 1'b1;
    push(16'h3333);
    cycle();
    chk("fl_occ", Occupancy, 0);
    chk("fl_valid", OutValid, 0);
    chk("fl_data", DataOut, 0);
    chk("hold_fl_data", h_data_out, 0);
    chk("hold_fl_ctrl", h_ctrl_out, 0);
    Flush = 1'b0;
    InValid = 1'b0;
    OutReady = 1'b1;
    cycle();
    chk("fl_after_occ", Occupancy, 0);
    chk("fl_after_data", DataOut, 0);

    // flush in ONE discards a beat that would otherwise be accepted
    OutReady = 1'b0;
    push(16'h6666);
    cycle();
    Flush = 1'b1;
    push(16'h3333);
    cycle();
    chk("fl1_occ", Occupancy, 0);
    chk("hold_fl1_data", h_data_out, 0);
    Flush = 1'b0;
    InValid = 1'b0;
    cycle();
    chk("fl1_after_occ", Occupancy, 0);

    // async reset between edges while FULL
    push(16'h7777);
    cycle();
    push(16'h8888);
    cycle();
    InValid = 1'b0;
    chk("ar_full_occ", Occupancy, 2);
    #2;
    Rst = 1'b1;
    #1;
    chk("ar_occ", Occupancy, 0);
    chk("ar_inready", InReady, 0);
    chk("ar_valid", OutValid, 0);
    chk("ar_data", DataOut, 0);
    chk("ar_ctrl", CtrlOut, 0);
    chk("hold_ar_data", h_data_out, 0);
    #1;
    Rst = 1'b0;
    #1;
    chk("ar_rel_inready", InReady, 1);
    OutReady = 1'b1;
    push(16'h1234);
    cycle();
    chk("ar_resume_data", DataOut, 16'h1234);
    chk("ar_resume_occ", Occupancy, 1);
    InValid = 1'b0;
    cycle();
    chk("ar_resume_empty", OutValid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
